// File: rtl/q15_pkg.sv
// Shared constants, width and state encoding for the Q16.48 dot-product accumulator.
package q15_pkg;

    localparam int unsigned Q15_W = 64;

    localparam logic [Q15_W-1:0] Q15_NAN     = 64'h8000_0000_0000_0000;
    localparam logic [Q15_W-1:0] Q15_POS_INF = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [Q15_W-1:0] Q15_NEG_INF = 64'h8000_0000_0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } q15_state_t;

endpackage

// File: rtl/q15_sat_adder.sv
// Combinational special-value-aware adder for the Q16.48 encoding:
// NaN and infinities propagate, finite sums saturate to +/-inf instead of wrapping.
module q15_sat_adder
    import q15_pkg::*;
(
    input  logic [Q15_W-1:0] i_a,
    input  logic [Q15_W-1:0] i_b,
    output logic [Q15_W-1:0] o_sum
);

    localparam logic signed [Q15_W:0] SUM_MAX = 65'sh0_7FFF_FFFF_FFFF_FFFE;
    localparam logic signed [Q15_W:0] SUM_MIN = 65'sh1_8000_0000_0000_0002;

    logic signed [Q15_W:0] w_sum;
    logic                  w_a_nan, w_b_nan, w_a_pinf, w_b_pinf, w_a_ninf, w_b_ninf;

    always_comb begin
        w_a_nan  = (i_a == Q15_NAN);
        w_b_nan  = (i_b == Q15_NAN);
        w_a_pinf = (i_a == Q15_POS_INF);
        w_b_pinf = (i_b == Q15_POS_INF);
        w_a_ninf = (i_a == Q15_NEG_INF);
        w_b_ninf = (i_b == Q15_NEG_INF);
        w_sum    = $signed({i_a[Q15_W-1], i_a}) + $signed({i_b[Q15_W-1], i_b});

        o_sum = w_sum[Q15_W-1:0];
        if (w_a_nan || w_b_nan) begin
            o_sum = Q15_NAN;
        end else if ((w_a_pinf && w_b_ninf) || (w_a_ninf && w_b_pinf)) begin
            o_sum = Q15_NAN;
        end else if (w_a_pinf || w_b_pinf) begin
            o_sum = Q15_POS_INF;
        end else if (w_a_ninf || w_b_ninf) begin
            o_sum = Q15_NEG_INF;
        end else if (w_sum > SUM_MAX) begin
            o_sum = Q15_POS_INF;
        end else if (w_sum < SUM_MIN) begin
            o_sum = Q15_NEG_INF;
        end
    end

endmodule

// File: rtl/q15_dot_accumulator.sv
// Streaming dot-product accumulator: sums Q16.48 terms until in_last, then holds the result.
// Optional term counter on out_count is enabled by defining Q15_DOT_COUNT_EN.
module q15_dot_accumulator
    import q15_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Q15_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef Q15_DOT_COUNT_EN
    output logic [CNT_W-1:0] out_count,
`endif
    output logic [Q15_W-1:0] out_data
);

    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("CNT_W must be in 1..16");
    end

    q15_state_t       r_state, w_state_nxt;
    logic [Q15_W-1:0] r_acc;
    logic [Q15_W-1:0] w_sum;
    logic             w_accept;
    logic             w_clear;

    q15_sat_adder u_adder (
        .i_a   (r_acc),
        .i_b   (in_data),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        w_accept    = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                w_clear   = out_ready;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // First term of a sum loads directly so a held NaN/inf never leaks into the next sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= (r_state == ST_IDLE) ? in_data : w_sum;
        end else if (w_clear) begin
            r_acc <= '0;
        end
    end

`ifdef Q15_DOT_COUNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            if (r_count != '1) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_clear) begin
            r_count <= '0;
        end
    end

    assign out_count = (r_state == ST_HOLD) ? r_count : '0;
`endif

endmodule

// File: tb/tb_q15_dot_accumulator.sv
// Directed self-checking bench for q15_dot_accumulator (hand-computed expected sums).
module tb_q15_dot_accumulator;

    localparam int unsigned CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
`ifdef Q15_DOT_COUNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    q15_dot_accumulator #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef Q15_DOT_COUNT_EN
        .out_count (out_count),
`endif
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one term, check it is acceptable, and return #1 after the accepting edge.
    task automatic send(input logic [63:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        check_eq("send_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Called right after the in_last handshake: result must already be presented.
    task automatic expect_result(input string tag, input logic [63:0] exp);
        check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check_eq({tag, "_data"}, out_data, exp);
        check_eq({tag, "_hold_rdy"}, {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_rel_valid"}, {63'd0, out_valid}, 64'd0);
        check_eq({tag, "_rel_data"}, out_data, 64'd0);
        check_eq({tag, "_rel_rdy"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst_data", out_data, 64'd0);
`ifdef Q15_DOT_COUNT_EN
        check_eq("rst_count", {56'd0, out_count}, 64'd0);
`endif
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Three times 1.0
        send(64'h0001_0000_0000_0000, 1'b0);
        check_eq("acc_no_valid", {63'd0, out_valid}, 64'd0);
        check_eq("acc_data_zero", out_data, 64'd0);
        send(64'h0001_0000_0000_0000, 1'b0);
        send(64'h0001_0000_0000_0000, 1'b1);
`ifdef Q15_DOT_COUNT_EN
        check_eq("count3", {56'd0, out_count}, 64'd3);
`endif
        expect_result("sum3", 64'h0003_0000_0000_0000);

        // Positive overflow saturates to +inf
        send(64'h7FFF_0000_0000_0000, 1'b0);
        send(64'h7FFF_0000_0000_0000, 1'b1);
        expect_result("pos_sat", 64'h7FFF_FFFF_FFFF_FFFF);

        // Negative overflow saturates to -inf: (-2^63+2) + (-1) = -2^63+1
        send(64'h8000_0000_0000_0002, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        expect_result("neg_sat", 64'h8000_0000_0000_0001);

        // +inf + -inf -> NaN, NaN persists through finite term
        send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'h8000_0000_0000_0001, 1'b0);
        send(64'h0001_0000_0000_0000, 1'b1);
        expect_result("nan_persist", 64'h8000_0000_0000_0000);

        // +inf absorbs finite terms
        send(64'h0005_0000_0000_0000, 1'b0);
        send(64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'hFFF0_0000_0000_0000, 1'b1);
        expect_result("pinf_absorb", 64'h7FFF_FFFF_FFFF_FFFF);

        // Mixed-sign finite: -1.0 + 0.5 = -0.5
        send(64'hFFFF_0000_0000_0000, 1'b0);
        send(64'h0000_8000_0000_0000, 1'b1);
        expect_result("neg_half", 64'hFFFF_8000_0000_0000);

        // A full-scale finite max alone stays finite-max... exactly at limit
        send(64'h7FFF_FFFF_FFFF_FFFE, 1'b0);
        send(64'h0000_0000_0000_0000, 1'b1);
        expect_result("at_max", 64'h7FFF_FFFF_FFFF_FFFE);

        // in_last with in_valid low is ignored
        in_valid = 1'b0;
        in_last  = 1'b1;
        in_data  = 64'h0005_0000_0000_0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("novalid_out", {63'd0, out_valid}, 64'd0);
        end
        in_last = 1'b0;
        send(64'h0001_0000_0000_0000, 1'b1);
        expect_result("after_novalid", 64'h0001_0000_0000_0000);

        // Backpressure: result held stable, extra input refused
        send(64'hFFFF_0000_0000_0000, 1'b1);
        in_valid = 1'b1;
        in_data  = 64'h0010_0000_0000_0000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", {63'd0, out_valid}, 64'd1);
            check_eq("bp_data", out_data, 64'hFFFF_0000_0000_0000);
            check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        out_ready = 1'b1;
        #1;
        check_eq("exit_bubble", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("exit_in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("exit_valid", {63'd0, out_valid}, 64'd0);

        // Reset mid-sum discards the partial result
        send(64'h0001_0000_0000_0000, 1'b0);
        send(64'h0001_0000_0000_0000, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("midrst_data", out_data, 64'd0);
        check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(64'h0002_0000_0000_0000, 1'b1);
`ifdef Q15_DOT_COUNT_EN
        check_eq("count1", {56'd0, out_count}, 64'd1);
`endif
        expect_result("post_rst", 64'h0002_0000_0000_0000);

        // Reset while holding a result drops it
        send(64'h0004_0000_0000_0000, 1'b1);
        check_eq("hold_pre_rst", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("holdrst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("holdrst_data", out_data, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("holdrst_in_ready", {63'd0, in_ready}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/q15_dot_accumulator.md
Q15_DOT_ACCUMULATOR -- requirements
Module: q15_dot_accumulator

Interface
REQ-001 Parameter CNT_W, default 8, term-counter width; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  in_data/in_last carry a valid term.
REQ-005 in_ready  output  1  block accepts a term this cycle.
REQ-006 in_data  input  64  signed Q16.48 product term, output encoding of the Q15 multiplier.
REQ-007 in_last  input  1  marks the final term of a dot product.
REQ-008 out_valid  output  1  out_data holds a completed sum.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_data  output  64  signed Q16.48 accumulated sum, same encoding.
REQ-011 out_count  output  CNT_W  terms in the sum; present only with Q15_DOT_COUNT_EN.

Function
REQ-012 Encoding: NaN = 0x8000_0000_0000_0000, +inf = 0x7FFF_FFFF_FFFF_FFFF, -inf = 0x8000_0000_0000_0001, finite = all other values.
REQ-013 States: IDLE (empty), ACCUM (partial sum held), HOLD (result presented).
REQ-014 in_ready = 1 in IDLE and ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-015 Term accepted when in_valid & in_ready; no other input changes state.
REQ-016 IDLE accept: acc <= term; next state ACCUM, or HOLD if in_last.
REQ-017 ACCUM accept: acc <= acc (+) term; stay ACCUM, or HOLD if in_last.
REQ-018 (+) rules, in priority order: NaN if either operand is NaN; NaN if one operand is +inf and the other -inf; inf of that sign if either operand is inf; otherwise exact 65-bit sum.
REQ-019 Finite sum above 0x7FFF_FFFF_FFFF_FFFE gives +inf; sum below 0x8000_0000_0000_0002 gives -inf; never wraps.
REQ-020 Latency: out_valid rises the cycle after the in_last handshake.
REQ-021 out_data equals acc in HOLD and stays stable until out_ready.
REQ-022 HOLD with out_ready = 1: next state IDLE, acc cleared to 0.
REQ-023 In the HOLD-exit cycle, in_ready stays 0, giving one bubble cycle.
REQ-024 A term with in_valid = 0 is never accumulated, whatever in_last is.
REQ-025 out_data = 0 outside HOLD.

Reset
REQ-026 rst_n low: state IDLE, acc = 0, out_valid = 0, out_data = 0, out_count = 0, in_ready = 1 after release.
REQ-027 Reset mid-sum or in HOLD discards the partial or pending result with no output.

Configuration
REQ-028 Macro Q15_DOT_COUNT_EN defined: counter increments on each accepted term, saturates at 2^CNT_W-1, shown on out_count in HOLD, cleared with acc.
REQ-029 Macro Q15_DOT_COUNT_EN absent: no out_count port and no counter logic; all other behaviour is identical.

Structure
REQ-030 Shared package q15_pkg holds: Q15_NAN, Q15_POS_INF and Q15_NEG_INF constants; Q15 width constant (64); the state enum.
REQ-031 One combinational sub-module, q15_sat_adder, implements REQ-018/REQ-019; the accumulator instantiates it once.

Verification
REQ-032 Accept 3 terms 0x0001_0000_0000_0000 (1.0) each, in_last on the third -> out_valid one cycle later, out_data 0x0003_0000_0000_0000, out_count 3.
REQ-033 Accept 0x7FFF_0000_0000_0000 then 0x7FFF_0000_0000_0000 (last) -> out_data 0x7FFF_FFFF_FFFF_FFFF.
REQ-034 Accept +inf then -inf, then finite 1.0 (last) -> out_data 0x8000_0000_0000_0000 (NaN persists).
REQ-035 Single term 0xFFFF_0000_0000_0000 with in_last, out_ready held 0 for 5 cycles -> out_valid and out_data stable and in_ready 0 throughout; after out_ready pulse -> IDLE and in_ready 1 one cycle later.
REQ-036 rst_n low after 2 accepted terms of a 4-term sum -> all outputs 0 immediately; next single-term sum of 2.0 -> out_data 0x0002_0000_0000_0000.
